transmissor_paridade: RTL and testbench
=======================================

# transmissor_paridade

Serial transmitter for the parity-protected 5-bit display code. It accepts a 5-bit symbol index over a valid/ready handshake and appends an odd-parity bit to form a 6-bit word. It serializes the word with a start bit and a stop bit onto a single line. It is the sending end of the link whose receiving side decodes the 6-bit word, checks parity and drives the 7-segment display.

## Interface
Parameters:
- CLKS_PER_BIT, default 4: clock cycles each serial bit is held; legal range 1..255.

Ports:
- clk  input  1  single clock; all state changes on its rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- dado  input  5  symbol index; sampled only on handshake.
- dado_valido  input  1  producer has a symbol on dado.
- pronto  output  1  block can accept a symbol.
- tx  output  1  serial line; idle high.
- quadro  output  6  word latched for the current frame: {parity, dado}. Holds the last value after the frame ends.
- ocupado  output  1  frame in progress (inverse of pronto).

## Operation
- Parity is odd over all 6 bits: quadro[5] = ~^dado. Examples: 5'b00000 gives 6'b100000; 5'b00011 gives 6'b100011; 5'b00111 gives 6'b000111.
- Handshake: a transfer occurs on a rising edge where dado_valido && pronto. On that edge the block latches quadro and the FSM leaves OCIOSO. dado_valido while pronto=0 is ignored; nothing is queued.
- Frame on tx, LSB first:
  - start bit 0;
  - quadro[0]..quadro[4];
  - quadro[5] (parity);
  - stop bit 1.
  - 8 bits total, each held CLKS_PER_BIT cycles.
- FSM states and transitions:
  - OCIOSO: tx=1, pronto=1. Goes to INICIO on handshake.
  - INICIO: tx=0. Goes to DADOS after CLKS_PER_BIT cycles.
  - DADOS: tx=quadro[indice], indice 0..4. Goes to PARIDADE after 5 bit periods.
  - PARIDADE: tx=quadro[5]. Goes to PARADA after one bit period.
  - PARADA: tx=1. Goes to OCIOSO after one bit period.
- Counters:
  - Bit-period counter: width $clog2(CLKS_PER_BIT), minimum 1. Counts 0..CLKS_PER_BIT-1 and wraps to 0 at each bit boundary.
  - indice: 3 bits. Resets to 0 on entry to DADOS.
- Codes 20..31 are transmitted unchanged; rejecting them is the receiver's job.
- Reset values: tx=1, pronto=1, ocupado=0, quadro=6'b000000, state OCIOSO, counters 0.
- Reset asserted mid-frame: tx goes to 1 immediately (asynchronously), the frame is abandoned, and nothing is resumed after release.

## Timing
- tx and all outputs are registered; no combinational path from inputs to tx.
- Latency: if the handshake occurs on edge k, the start bit is on tx from edge k to edge k+CLKS_PER_BIT.
- Frame length: 8*CLKS_PER_BIT cycles from handshake to return to OCIOSO.
- Back-to-back: pronto is high for at least one cycle between frames. With dado_valido held high, frames start every 8*CLKS_PER_BIT+1 cycles.
- quadro updates only on the handshake edge.

## Configuration
- PARIDADE_INJECAO_ERRO_EN defined:
  - Adds input forca_erro (1 bit), sampled on the handshake edge.
  - When forca_erro=1, the parity bit is inverted in both quadro[5] and the frame. The receiver then sees a parity error.
- Not defined: the port is absent and parity is always correct.

## Structure
- Shared package pacote_display holds:
  - LARGURA_QUADRO=6 and LARGURA_DADO=5;
  - the FSM state enum (OCIOSO, INICIO, DADOS, PARIDADE, PARADA);
  - function paridade_impar(dado), also usable by the receiver side.
- One sub-module is natural: gerador_paridade, combinational, 5-bit in, 6-bit word out, with an optional inversion input.
- The serializer FSM and counters live in transmissor_paridade.

## Test plan
- Reset then idle, CLKS_PER_BIT=4: tx=1, pronto=1, quadro=0 for 20 cycles with dado_valido=0.
- dado=5'b00011, one-cycle valid: quadro=6'b100011. tx holds each of 0,1,1,0,0,0,1,1 for 4 cycles, with the start bit beginning the edge after the handshake. pronto returns high after 32 cycles.
- dado=5'b00000 then 5'b00111 with valid held high: frames carry parity bits 1 then 0. The second start bit begins 33 cycles after the first.
- Pulse dado_valido with dado=5'b10010 during cycle 10 of a frame: ignored. The current frame is unchanged and no second frame is sent.
- Assert rst_n=0 during the DADOS state: tx=1 within the same cycle and pronto=1. After release, a new handshake produces a complete frame.
- With PARIDADE_INJECAO_ERRO_EN, dado=5'b00001 and forca_erro=1: quadro=6'b100001 and the parity bit on tx is 1 instead of 0.

Source files
------------

// File: rtl/transmissor_paridade_pkg.sv
// pacote_display: shared definitions for the parity-protected 5-bit display link.
// Contents: word/data widths, frame payload struct, serializer FSM state
// enum and the odd-parity helper (also usable by the receiving side).
package pacote_display;

  localparam int unsigned LARGURA_DADO   = 5;
  localparam int unsigned LARGURA_QUADRO = 6;

  // Frame payload as latched and serialized: {parity, symbol}.
  typedef struct packed {
    logic                    paridade;
    logic [LARGURA_DADO-1:0] dado;
  } quadro_t;

  // Serializer states.
  typedef enum logic [2:0] {
    OCIOSO   = 3'd0,
    INICIO   = 3'd1,
    DADOS    = 3'd2,
    PARIDADE = 3'd3,
    PARADA   = 3'd4
  } estado_t;

  // Odd parity: the returned bit makes the 6-bit word contain an odd number of ones.
  function automatic logic paridade_impar(input logic [LARGURA_DADO-1:0] dado);
    return ~^dado;
  endfunction

endpackage

// File: rtl/transmissor_paridade_gerador_paridade.sv
// gerador_paridade: combinational builder of the 6-bit word {parity, symbol}.
// Ports:
//   dado_i     symbol index (5 bits)
//   inverte_i  invert the parity bit (error injection; tie to 0 when unused)
//   palavra_c  resulting word, combinational
module gerador_paridade
  import pacote_display::*;
(
  input  logic [LARGURA_DADO-1:0] dado_i,
  input  logic                    inverte_i,
  output quadro_t                 palavra_c
);

  assign palavra_c.paridade = paridade_impar(dado_i) ^ inverte_i;
  assign palavra_c.dado     = dado_i;

endmodule

// File: rtl/transmissor_paridade.sv
// transmissor_paridade: serial transmitter for the parity-protected 5-bit
// display code. Accepts a symbol over valid/ready, forms {odd parity, dado}
// and sends start(0), quadro[0..5] LSB first, stop(1), each bit held
// CLKS_PER_BIT cycles.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   dado         symbol index, sampled on handshake
//   dado_valido  producer has a symbol
//   pronto       block accepts a symbol (registered)
//   tx           serial line, idle high (registered)
//   quadro       word of the current/last frame (registered)
//   ocupado      frame in progress (registered, inverse of pronto)
//   forca_erro   present only when PARIDADE_INJECAO_ERRO_EN is defined:
//                inverts the parity bit of the frame accepted on that edge
module transmissor_paridade
  import pacote_display::*;
#(
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [LARGURA_DADO-1:0]   dado,
  input  logic                      dado_valido,
`ifdef PARIDADE_INJECAO_ERRO_EN
  input  logic                      forca_erro,
`endif
  output logic                      pronto,
  output logic                      tx,
  output logic [LARGURA_QUADRO-1:0] quadro,
  output logic                      ocupado
);

  localparam int unsigned LARGURA_CNT = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [LARGURA_CNT-1:0] CNT_ULTIMO = LARGURA_CNT'(CLKS_PER_BIT - 1);
  localparam logic [2:0]             IDX_ULTIMO = 3'(LARGURA_DADO - 1);

  estado_t                estado_q, estado_d;
  logic [LARGURA_CNT-1:0] cnt_q, cnt_d;
  logic [2:0]             indice_q, indice_d;
  quadro_t                quadro_q, quadro_d;
  logic                   tx_q, tx_d;
  logic                   pronto_q, pronto_d;
  logic                   ocupado_q, ocupado_d;

  quadro_t palavra_c;
  logic    inverte_c;
  logic    fim_bit_c;

`ifdef PARIDADE_INJECAO_ERRO_EN
  assign inverte_c = forca_erro;
`else
  assign inverte_c = 1'b0;
`endif

  gerador_paridade u_gerador (
    .dado_i    (dado),
    .inverte_i (inverte_c),
    .palavra_c (palavra_c)
  );

  assign fim_bit_c = (cnt_q == CNT_ULTIMO);

  // Next state, counters and registered outputs.
  always_comb begin
    estado_d  = estado_q;
    cnt_d     = '0;
    indice_d  = indice_q;
    quadro_d  = quadro_q;
    tx_d      = 1'b1;
    pronto_d  = 1'b1;
    ocupado_d = 1'b0;

    if (estado_q != OCIOSO) begin
      cnt_d = fim_bit_c ? '0 : cnt_q + LARGURA_CNT'(1);
    end

    case (estado_q)
      OCIOSO: begin
        if (dado_valido && pronto_q) begin
          estado_d = INICIO;
          quadro_d = palavra_c;
        end
      end
      INICIO: begin
        if (fim_bit_c) begin
          estado_d = DADOS;
          indice_d = '0;
        end
      end
      DADOS: begin
        if (fim_bit_c) begin
          if (indice_q == IDX_ULTIMO) begin
            estado_d = PARIDADE;
          end else begin
            indice_d = indice_q + 3'd1;
          end
        end
      end
      PARIDADE: begin
        if (fim_bit_c) estado_d = PARADA;
      end
      PARADA: begin
        if (fim_bit_c) estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase

    // tx is derived from the state being entered so the line is registered
    // yet changes on the same edge as the state.
    case (estado_d)
      INICIO:   tx_d = 1'b0;
      DADOS:    tx_d = quadro_d.dado[indice_d];
      PARIDADE: tx_d = quadro_d.paridade;
      default:  tx_d = 1'b1;
    endcase

    pronto_d  = (estado_d == OCIOSO);
    ocupado_d = ~pronto_d;
  end

  // State and output registers; tx resets high asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado_q  <= OCIOSO;
      cnt_q     <= '0;
      indice_q  <= '0;
      quadro_q  <= '0;
      tx_q      <= 1'b1;
      pronto_q  <= 1'b1;
      ocupado_q <= 1'b0;
    end else begin
      estado_q  <= estado_d;
      cnt_q     <= cnt_d;
      indice_q  <= indice_d;
      quadro_q  <= quadro_d;
      tx_q      <= tx_d;
      pronto_q  <= pronto_d;
      ocupado_q <= ocupado_d;
    end
  end

  assign tx      = tx_q;
  assign pronto  = pronto_q;
  assign ocupado = ocupado_q;
  assign quadro  = quadro_q;

endmodule

// File: tb/tb_transmissor_paridade.sv
// Testbench for transmissor_paridade (CLKS_PER_BIT=4). The driver pushes the
// expected word and handshake edge into a queue; a monitor detects each start
// bit on tx, pops the expectation and checks timing, quadro and every bit.
module tb_transmissor_paridade;

  localparam int unsigned C = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] dado = 5'd0;
  logic       dado_valido = 1'b0;
  logic       pronto;
  logic       tx;
  logic [5:0] quadro;
  logic       ocupado;
`ifdef PARIDADE_INJECAO_ERRO_EN
  logic       forca_erro = 1'b0;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  typedef struct {
    logic [5:0] w;
    int         ciclo;
  } esperado_t;

  esperado_t fila[$];
  int        inicios[$];
  bit        em_quadro = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  transmissor_paridade #(.CLKS_PER_BIT(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .dado        (dado),
    .dado_valido (dado_valido),
`ifdef PARIDADE_INJECAO_ERRO_EN
    .forca_erro  (forca_erro),
`endif
    .pronto      (pronto),
    .tx          (tx),
    .quadro      (quadro),
    .ocupado     (ocupado)
  );

  task automatic chk(input string nome, input logic [31:0] atual, input logic [31:0] esperado);
    checks++;
    if (atual !== esperado) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nome, atual, esperado);
    end
  endtask

  // Reference: parity bit chosen so the word holds an odd number of ones.
  function automatic logic [5:0] modelo(input logic [4:0] d, input bit fe);
    int  uns;
    bit  p;
    uns = $countones(d);
    p   = ((uns % 2) == 0);
    p   = p ^ fe;
    return {p, d};
  endfunction

  task automatic envia(input logic [4:0] d, input bit fe, input bit manter);
    bit feito;
    bit fe_ef;
    feito = 1'b0;
`ifdef PARIDADE_INJECAO_ERRO_EN
    fe_ef = fe;
`else
    fe_ef = 1'b0;
`endif
    @(negedge clk);
    dado = d;
    dado_valido = 1'b1;
`ifdef PARIDADE_INJECAO_ERRO_EN
    forca_erro = fe_ef;
`endif
    for (int i = 0; i < 200 && !feito; i++) begin
      if (pronto === 1'b1) begin
        fila.push_back('{modelo(d, fe_ef), cyc + 1});
        feito = 1'b1;
      end else begin
        @(negedge clk);
      end
    end
    chk("handshake_timeout", 32'(feito), 32'd1);
    @(posedge clk);
    #1;
    if (!manter) dado_valido = 1'b0;
  endtask

  task automatic aguarda_ocioso();
    bit feito;
    feito = 1'b0;
    for (int i = 0; i < 2000 && !feito; i++) begin
      @(negedge clk);
      if (fila.size() == 0 && !em_quadro && pronto === 1'b1) feito = 1'b1;
    end
    chk("aguarda_ocioso", 32'(feito), 32'd1);
  endtask

  // Monitor: one frame per falling edge of an idle line.
  initial begin : monitor
    logic      tx_ant;
    esperado_t e;
    logic [7:0] bits;
    bit        abortado;
    bit        ok;
    tx_ant = 1'b1;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && tx_ant === 1'b1 && tx === 1'b0) begin
        em_quadro = 1'b1;
        inicios.push_back(cyc);
        if (fila.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL quadro_inesperado: frame started at cycle %0d with nothing expected", cyc);
        end else begin
          e = fila.pop_front();
          chk("inicio_ciclo", 32'(cyc), 32'(e.ciclo));
          chk("quadro", 32'(quadro), 32'(e.w));
          bits = {1'b1, e.w, 1'b0};
          abortado = 1'b0;
          for (int b = 0; b < 8 && !abortado; b++) begin
            ok = 1'b1;
            for (int j = 0; j < int'(C) && !abortado; j++) begin
              if (b != 0 || j != 0) begin
                @(negedge clk);
                if (rst_n !== 1'b1) abortado = 1'b1;
              end
              if (!abortado && (tx !== bits[b] || pronto !== 1'b0 || ocupado !== 1'b1)) ok = 1'b0;
            end
            if (!abortado) chk($sformatf("bit%0d", b), 32'(ok), 32'd1);
          end
          if (!abortado) begin
            @(negedge clk);
            chk("pronto_fim", 32'(pronto), 32'd1);
          end
        end
        em_quadro = 1'b0;
      end
      tx_ant = tx;
    end
  end

  initial begin : estimulo
    bit   ok;
    int   n;
    logic [4:0] d;
    bit   fe;
    bit   manter;

    repeat (3) @(negedge clk);
    chk("reset_tx", 32'(tx), 32'd1);
    chk("reset_pronto", 32'(pronto), 32'd1);
    chk("reset_ocupado", 32'(ocupado), 32'd0);
    chk("reset_quadro", 32'(quadro), 32'd0);
    rst_n = 1'b1;

    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (tx !== 1'b1 || pronto !== 1'b1 || quadro !== 6'd0) ok = 1'b0;
    end
    chk("ocioso_20", 32'(ok), 32'd1);

    envia(5'b00011, 1'b0, 1'b0);
    chk("quadro_00011", 32'(quadro), 32'b100011);
    aguarda_ocioso();

    n = inicios.size();
    envia(5'b00000, 1'b0, 1'b1);
    chk("quadro_00000", 32'(quadro), 32'b100000);
    envia(5'b00111, 1'b0, 1'b0);
    chk("quadro_00111", 32'(quadro), 32'b000111);
    aguarda_ocioso();
    if (inicios.size() >= n + 2) begin
      chk("espaco_b2b", 32'(inicios[n+1] - inicios[n]), 32'(8 * C + 1));
    end else begin
      checks++;
      failures++;
      $display("FAIL espaco_b2b: got %0d frames expected 2", inicios.size() - n);
    end

    n = inicios.size();
    envia(5'b01100, 1'b0, 1'b0);
    repeat (9) @(negedge clk);
    dado = 5'b10010;
    dado_valido = 1'b1;
    @(negedge clk);
    dado_valido = 1'b0;
    aguarda_ocioso();
    repeat (40) @(negedge clk);
    chk("pulso_ignorado", 32'(inicios.size() - n), 32'd1);
    chk("quadro_mantido", 32'(quadro), 32'b101100);

    envia(5'b10101, 1'b0, 1'b0);
    repeat (C + 2) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_meio_tx", 32'(tx), 32'd1);
    chk("rst_meio_pronto", 32'(pronto), 32'd1);
    chk("rst_meio_ocupado", 32'(ocupado), 32'd0);
    chk("rst_meio_quadro", 32'(quadro), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n = inicios.size();
    repeat (10) @(negedge clk);
    chk("sem_retomada", 32'(inicios.size() - n), 32'd0);
    envia(5'b11110, 1'b0, 1'b0);
    aguarda_ocioso();

`ifdef PARIDADE_INJECAO_ERRO_EN
    envia(5'b00001, 1'b1, 1'b0);
    chk("quadro_erro", 32'(quadro), 32'b100001);
    aguarda_ocioso();
`endif

    for (int i = 0; i < 12; i++) begin
      d = 5'($urandom_range(0, 31));
      fe = 1'($urandom_range(0, 1));
      manter = (i < 11) ? 1'($urandom_range(0, 1)) : 1'b0;
      envia(d, fe, manter);
      if (!manter) repeat ($urandom_range(0, 3)) @(negedge clk);
    end
    aguarda_ocioso();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
